seg7_reader: RTL

Receiving end of the hex-to-7-segment display path. The block samples a 7-segment drive pattern (segments a..g) and waits until the pattern has been stable for a programmable number of cycles. It then decodes the pattern back to a 4-bit hex value and flags blank or illegal patterns. It sits on a board-to-board or loopback segment bus, so the bench and board can confirm what a state machine is showing on the display.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_pattern_to_hex.sv | 39 +++
 rtl/seg7_reader.sv | 112 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment read-back path: active-high glyphs
// (segment a is bit 6) and the reader's state encoding.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h7E;
  localparam logic [6:0] GLYPH_1 = 7'h30;
  localparam logic [6:0] GLYPH_2 = 7'h6D;
  localparam logic [6:0] GLYPH_3 = 7'h79;
  localparam logic [6:0] GLYPH_4 = 7'h33;
  localparam logic [6:0] GLYPH_5 = 7'h5B;
  localparam logic [6:0] GLYPH_6 = 7'h5F;
  localparam logic [6:0] GLYPH_7 = 7'h70;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h7B;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h1F;
  localparam logic [6:0] GLYPH_C = 7'h4E;
  localparam logic [6:0] GLYPH_D = 7'h3D;
  localparam logic [6:0] GLYPH_E = 7'h4F;
  localparam logic [6:0] GLYPH_F = 7'h47;
  localparam logic [6:0] BLANK   = 7'h00;

  typedef enum logic {
    TRACK  = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// Combinational decode of an active-high segment pattern back to a hex digit.
// Only canonical glyphs decode; all-off is blank, anything else is an error.
module seg7_pattern_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] value,
  output logic       err,
  output logic       blank
);

  // Table lookup; non-glyph patterns report value 0.
  always_comb begin
    value = 4'h0;
    err   = 1'b0;
    blank = 1'b0;
    case (pat)
      GLYPH_0: value = 4'h0;
      GLYPH_1: value = 4'h1;
      GLYPH_2: value = 4'h2;
      GLYPH_3: value = 4'h3;
      GLYPH_4: value = 4'h4;
      GLYPH_5: value = 4'h5;
      GLYPH_6: value = 4'h6;
      GLYPH_7: value = 4'h7;
      GLYPH_8: value = 4'h8;
      GLYPH_9: value = 4'h9;
      GLYPH_A: value = 4'hA;
      GLYPH_B: value = 4'hB;
      GLYPH_C: value = 4'hC;
      GLYPH_D: value = 4'hD;
      GLYPH_E: value = 4'hE;
      GLYPH_F: value = 4'hF;
      BLANK:   blank = 1'b1;
      default: err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples a 7-segment drive pattern, waits for it to be stable for
// STABLE_CYCLES cycles, then locks and reports the decoded hex digit.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sa,
  input  logic       sb,
  input  logic       sc,
  input  logic       sd,
  input  logic       se,
  input  logic       sf,
  input  logic       sg,
  output logic [3:0] value,
  output logic       valid,
  output logic       locked,
  output logic       err,
  output logic       blank,
  output logic [7:0] lock_count
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [6:0]       raw_s;
  logic [6:0]       pat_s;
  logic [6:0]       pat_q_r;
  logic [6:0]       cand_r;
  logic [CNT_W-1:0] cnt_r;
  state_e           state_r;
  state_e           state_s;
  logic             load_s;
  logic             inc_s;
  logic             lock_s;
  logic [3:0]       dec_value_s;
  logic             dec_err_s;
  logic             dec_blank_s;

  // Internally a set bit always means the segment is lit.
  assign raw_s = {sa, sb, sc, sd, se, sf, sg};
  assign pat_s = (SEG_ACTIVE_LOW != 1'b0) ? ~raw_s : raw_s;

  seg7_pattern_to_hex u_decode (
    .pat   (cand_r),
    .value (dec_value_s),
    .err   (dec_err_s),
    .blank (dec_blank_s)
  );

  // Next-state and action selection; a pattern change wins from any state.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    inc_s   = 1'b0;
    lock_s  = 1'b0;
    if (pat_q_r != cand_r) begin
      load_s  = 1'b1;
      state_s = TRACK;
    end else if (state_r == TRACK) begin
      if (cnt_r == CNT_TARGET) begin
        lock_s  = 1'b1;
        state_s = LOCKED;
      end else begin
        inc_s = 1'b1;
      end
    end else begin
      state_s = state_r;
    end
  end

  // Sample register, stability counter, state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q_r    <= 7'h00;
      cand_r     <= 7'h00;
      cnt_r      <= '0;
      state_r    <= TRACK;
      value      <= 4'h0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      blank      <= 1'b0;
      lock_count <= 8'h00;
    end else begin
      pat_q_r <= pat_s;
      state_r <= state_s;
      valid   <= lock_s;
      if (load_s) begin
        // Losing lock leaves the last decoded digit visible.
        cand_r <= pat_q_r;
        cnt_r  <= CNT_ONE;
        locked <= 1'b0;
      end else if (lock_s) begin
        locked     <= 1'b1;
        value      <= dec_value_s;
        err        <= dec_err_s;
        blank      <= dec_blank_s;
        lock_count <= lock_count + 8'd1;
      end else if (inc_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule
